// File: rtl/pointwise_conv_engine.sv
// pointwise_conv_engine: streaming 1x1 convolution with per-lane biased MAC, saturation and optional ReLU
module pointwise_conv_engine #(
  parameter int WIDTH = 16,
  parameter int FRAC = 14,
  parameter int DSP_NO = 256,
  parameter int CHIN = 112,
  parameter int OUT_PIX = 64,
  parameter int RELU = 1,
  parameter int ACC_W = 2*WIDTH+$clog2(CHIN)+1,
  localparam int AW = CHIN > 1 ? $clog2(CHIN) : 1,
  localparam int PW = OUT_PIX > 1 ? $clog2(OUT_PIX) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [WIDTH-1:0]        ifm,
  input  logic                    ifm_valid,
  output logic                    ifm_ready,
  output logic [AW-1:0]           weight_addr,
  input  logic [DSP_NO*WIDTH-1:0] weight_data,
  input  logic [DSP_NO*WIDTH-1:0] bias,
  output logic [DSP_NO*WIDTH-1:0] ofm,
  output logic                    ofm_valid,
  input  logic                    ofm_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  state_t state, state_nx;
  logic [AW-1:0] ch_cnt;
  logic [PW-1:0] pix_cnt;
  logic signed [ACC_W-1:0] acc [DSP_NO];
  logic signed [ACC_W-1:0] sum [DSP_NO];
  logic [DSP_NO*WIDTH-1:0] res;
  logic in_hs, out_hs, first_ch, last_ch, last_pix;
  assign first_ch = ch_cnt == '0;
  assign last_ch = ch_cnt == AW'(CHIN-1);
  assign last_pix = pix_cnt == PW'(OUT_PIX-1);
  assign ifm_ready = state == RUN && !(last_ch && ofm_valid && !ofm_ready);
  assign in_hs = ifm_valid && ifm_ready;
  assign out_hs = ofm_valid && ofm_ready;
  assign busy = state != IDLE;
  assign weight_addr = ch_cnt;
  // Per lane: biased MAC, arithmetic rescale, saturation and optional ReLU
  for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
    logic signed [2*WIDTH-1:0] a, w, p;
    logic signed [ACC_W-1:0] b, s;
    assign a = {{WIDTH{ifm[WIDTH-1]}}, ifm};
    assign w = {{WIDTH{weight_data[i*WIDTH+WIDTH-1]}}, weight_data[i*WIDTH +: WIDTH]};
    assign p = a * w;
    assign b = {{(ACC_W-WIDTH){bias[i*WIDTH+WIDTH-1]}}, bias[i*WIDTH +: WIDTH]} << FRAC;
    assign sum[i] = (first_ch ? b : acc[i]) + {{(ACC_W-2*WIDTH){p[2*WIDTH-1]}}, p};
    assign s = sum[i] >>> FRAC;
    assign res[i*WIDTH +: WIDTH] = (RELU != 0 && s[ACC_W-1]) ? '0 :
                                   s > MAXV ? MAXV[WIDTH-1:0] :
                                   s < MINV ? MINV[WIDTH-1:0] : s[WIDTH-1:0];
  end
  // Next-state logic
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = RUN;
    if (state == RUN && in_hs && last_ch && last_pix) state_nx = DRAIN;
    if (state == DRAIN && out_hs) state_nx = IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Channel/pixel counters, output register and completion pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ch_cnt <= '0;
      pix_cnt <= '0;
      ofm <= '0;
      ofm_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == DRAIN && out_hs;
      if (state == IDLE && start) begin
        ch_cnt <= '0;
        pix_cnt <= '0;
      end else if (in_hs) begin
        ch_cnt <= last_ch ? '0 : ch_cnt + AW'(1);
        if (last_ch) pix_cnt <= last_pix ? '0 : pix_cnt + PW'(1);
      end
      if (in_hs && last_ch) begin
        ofm <= res;
        ofm_valid <= 1'b1;
      end else if (out_hs) ofm_valid <= 1'b0;
    end
  // Accumulators follow every accepted activation
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int k = 0; k < DSP_NO; k++) acc[k] <= '0;
    else if (in_hs) for (int k = 0; k < DSP_NO; k++) acc[k] <= sum[k];
endmodule

// File: tb/tb_pointwise_conv_engine.sv
// tb_pointwise_conv_engine: table-driven and scoreboard bench for two lanes, four channels, two pixels
module tb_pointwise_conv_engine;
  localparam int W = 16, CHIN = 4, NPIX = 2, NL = 2, NV = 7;
  logic clk = 0, rst = 0, start = 0, ifm_valid = 0, ofm_ready = 1;
  logic [W-1:0] ifm = '0;
  logic [NL*W-1:0] weight_data, bias = '0;
  logic busy, done, ifm_ready, ofm_valid, busy_r, done_r, ifm_ready_r, ofm_valid_r;
  logic [1:0] weight_addr, weight_addr_r;
  logic [NL*W-1:0] ofm, ofm_r;
  logic [W-1:0] wrom [CHIN][NL];
  logic [W-1:0] ivals [NPIX][CHIN];
  typedef struct packed {logic [W-1:0] e0, e1, r0, r1;} exp_t;
  typedef struct {logic [W-1:0] a, w0, w1, b0, b1, e0, e1, r0, r1;} vec_t;
  exp_t expv [NPIX];
  exp_t sb [$];
  vec_t tbl [NV];
  int checks = 0, errors = 0, done_seen = 0;

  always #5 clk = ~clk;
  assign weight_data = {wrom[weight_addr][1], wrom[weight_addr][0]};

  pointwise_conv_engine #(.WIDTH(16), .FRAC(14), .DSP_NO(NL), .CHIN(CHIN), .OUT_PIX(NPIX), .RELU(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(ifm_ready), .weight_addr(weight_addr), .weight_data(weight_data), .bias(bias),
    .ofm(ofm), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready));

  pointwise_conv_engine #(.WIDTH(16), .FRAC(14), .DSP_NO(NL), .CHIN(CHIN), .OUT_PIX(NPIX), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .busy(busy_r), .done(done_r), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(ifm_ready_r), .weight_addr(weight_addr_r), .weight_data(weight_data), .bias(bias),
    .ofm(ofm_r), .ofm_valid(ofm_valid_r), .ofm_ready(ofm_ready));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  function automatic logic [W-1:0] sat(input longint a, input bit relu);
    longint s;
    s = a >>> 14;
    if (relu && s < 0) return '0;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic exp_t model(input int p);
    longint a0, a1;
    exp_t e;
    a0 = longint'($signed(bias[15:0])) * 16384;
    a1 = longint'($signed(bias[31:16])) * 16384;
    for (int c = 0; c < CHIN; c++) begin
      a0 += longint'($signed(ivals[p][c])) * longint'($signed(wrom[c][0]));
      a1 += longint'($signed(ivals[p][c])) * longint'($signed(wrom[c][1]));
    end
    e.e0 = sat(a0, 0); e.e1 = sat(a1, 0); e.r0 = sat(a0, 1); e.r1 = sat(a1, 1);
    return e;
  endfunction

  // Scoreboard consumer and done counter, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (done) done_seen++;
    if (ofm_valid && ofm_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL ofm_unexpected actual=%h required=none", ofm);
      end else begin
        e = sb.pop_front();
        chk("ofm", ofm, {e.e1, e.e0});
        chk("ofm_relu", ofm_r, {e.r1, e.r0});
        chk("ofm_valid_relu", ofm_valid_r, 1);
      end
    end
  end

  task automatic load_case(input vec_t v);
    for (int c = 0; c < CHIN; c++) begin
      wrom[c][0] = v.w0; wrom[c][1] = v.w1;
      for (int p = 0; p < NPIX; p++) ivals[p][c] = v.a;
    end
    bias = {v.b1, v.b0};
    for (int p = 0; p < NPIX; p++) expv[p] = '{v.e0, v.e1, v.r0, v.r1};
  endtask

  task automatic load_random();
    for (int c = 0; c < CHIN; c++) begin
      wrom[c][0] = W'($urandom); wrom[c][1] = W'($urandom);
      for (int p = 0; p < NPIX; p++) ivals[p][c] = W'($urandom);
    end
    bias = {W'($urandom), W'($urandom)};
    for (int p = 0; p < NPIX; p++) expv[p] = model(p);
  endtask

  task automatic do_start();
    chk("idle_busy", busy, 0);
    start = 1; @(posedge clk); #1; start = 0;
    chk("start_busy", busy, 1);
    chk("start_ifm_ready", ifm_ready, 1);
    chk("start_addr", weight_addr, 0);
  endtask

  task automatic send_beat(input logic [W-1:0] v, input int p, input int c, input int gap);
    int t, g;
    t = 0; g = 0;
    while (gap > 0 && g < 20 && $urandom_range(99) < gap) begin
      ifm_valid = 0; g++; @(posedge clk); #1;
    end
    ifm = v; ifm_valid = 1;
    if (c == CHIN-1) sb.push_back(expv[p]);
    @(negedge clk);
    while (!ifm_ready && t < 100) begin @(negedge clk); t++; end
    if (!ifm_ready) begin
      checks++; errors++;
      $display("FAIL ifm_ready_timeout actual=0 required=1");
    end
    chk("weight_addr", weight_addr, c);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int t, d0;
    t = 0; d0 = done_seen;
    ifm_valid = 0;
    @(negedge clk);
    while (!done && t < 200) begin @(negedge clk); t++; end
    chk("done_high", done, 1);
    chk("done_busy", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("done_count", done_seen - d0, 1);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_layer(input int gap);
    do_start();
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < CHIN; c++) send_beat(ivals[p][c], p, c, gap);
    wait_done();
  endtask

  initial begin
    int d0;
    logic [31:0] cap;
    int t;
    tbl[0] = '{16'h4000, 16'h2000, 16'hE000, 16'h0100, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
    tbl[1] = '{16'h4000, 16'hD000, 16'h5000, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF};
    tbl[2] = '{16'h2000, 16'h1000, 16'hF000, 16'h0400, 16'hFC00, 16'h2400, 16'hDC00, 16'h2400, 16'h0000};
    tbl[3] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
    tbl[5] = '{16'h4000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
    tbl[6] = '{16'h4000, 16'h0001, 16'hFFFF, 16'h7FFC, 16'h8004, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
    load_case(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ifm_ready", ifm_ready, 0);
    chk("rst_ofm_valid", ofm_valid, 0);
    chk("rst_ofm", ofm, 0);
    chk("rst_addr", weight_addr, 0);
    rst = 1;
    @(posedge clk); #1;
    for (int k = 0; k < NV; k++) begin
      load_case(tbl[k]);
      run_layer(0);
    end
    // Output backpressure for ten cycles after pixel 0
    load_case(tbl[2]);
    ofm_ready = 0;
    fork
      run_layer(0);
      begin
        t = 0;
        while (!ofm_valid && t < 200) begin @(negedge clk); t++; end
        chk("bp_valid", ofm_valid, 1);
        cap = ofm;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_ifm_ready", ifm_ready, weight_addr != 2'd3);
          chk("bp_hold", ofm, cap);
        end
        chk("bp_addr", weight_addr, 3);
        @(posedge clk); #1;
        ofm_ready = 1;
      end
    join
    // Random data, gapless then with ifm_valid gaps
    load_random();
    run_layer(0);
    run_layer(50);
    load_random();
    run_layer(50);
    // start pulse while busy is ignored
    load_case(tbl[2]);
    do_start();
    send_beat(ivals[0][0], 0, 0, 0);
    start = 1;
    send_beat(ivals[0][1], 0, 1, 0);
    start = 0;
    send_beat(ivals[0][2], 0, 2, 0);
    send_beat(ivals[0][3], 0, 3, 0);
    for (int c = 0; c < CHIN; c++) send_beat(ivals[1][c], 1, c, 0);
    wait_done();
    // Asynchronous reset at pixel 1, channel 2
    load_case(tbl[0]);
    d0 = done_seen;
    do_start();
    for (int c = 0; c < CHIN; c++) send_beat(ivals[0][c], 0, c, 0);
    send_beat(ivals[1][0], 1, 0, 0);
    send_beat(ivals[1][1], 1, 1, 0);
    chk("pre_rst_addr", weight_addr, 2);
    #2 rst = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ifm_ready", ifm_ready, 0);
    chk("arst_ofm_valid", ofm_valid, 0);
    chk("arst_ofm", ofm, 0);
    chk("arst_ofm_relu", ofm_r, 0);
    chk("arst_addr", weight_addr, 0);
    chk("arst_done", done, 0);
    ifm_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_done", done_seen - d0, 0);
    chk("arst_idle", busy, 0);
    run_layer(0);
    // start coincident with reset is ignored
    d0 = done_seen;
    rst = 0; start = 1;
    @(posedge clk); #1;
    rst = 1; start = 0;
    @(negedge clk);
    chk("srst_busy", busy, 0);
    chk("srst_ifm_ready", ifm_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("srst_no_done", done_seen - d0, 0);
    load_random();
    run_layer(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
